// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: register address width, forwarding-select encodings, scoreboard entry layout.
package hazard_scoreboard_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_NONE  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // operand from EX/MEM register
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // operand from MEM/WB register

  // One pending instruction as seen by the scoreboard. All-zero is a bubble.
  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              mem_read;
    logic [REG_AW-1:0] dest;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic              two_src;
  } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one scoreboard entry's destination against one source register.
// Latency: combinational.
// Backpressure: none; pure compare.
// Ports: ent_valid/ent_wb_en/ent_dest describe the pending writer; src/src_used
//        describe the reader; match is high when the reader depends on the writer.
module hazard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic          ent_valid,
  input  logic          ent_wb_en,
  input  logic [AW-1:0] ent_dest,
  input  logic [AW-1:0] src,
  input  logic          src_used,
  output logic          match
);

  // r0 is hard-wired to zero, so a write to it never creates a dependency.
  assign match = src_used && ent_valid && ent_wb_en &&
                 (ent_dest == src) && (src != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks EX/MEM/WB register writers and stalls the ID instruction on a RAW hazard.
// Latency: hazard_detected is combinational from ID inputs and registered entries.
// Backpressure: hazard_detected holds IF/ID and injects a bubble into EX; branch_taken squashes.
// Ports: clk/rst_n; id_* decoded ID instruction; branch_taken; hazard_detected;
//        stall_cnt (saturating); fwd_sel_a/fwd_sel_b only when HAZARD_FORWARDING_EN is defined.
// Build option: define HAZARD_FORWARDING_EN to stall only on load-use and drive EX forwarding selects.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW    = hazard_scoreboard_pkg::REG_AW,
  parameter int CNT_W     = 16,
  parameter int WB_HAZARD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_read,
  input  logic              branch_taken,
  output logic              hazard_detected,
  output logic [CNT_W-1:0]  stall_cnt
`ifdef HAZARD_FORWARDING_EN
  ,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b
`endif
);

  sb_entry_t ex_q, ex_d;
  sb_entry_t mem_q, mem_d;
  sb_entry_t wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Stage view indexed 0=ex, 1=mem, 2=wb for the comparator array.
  sb_entry_t stage [3];
  logic [2:0] src1_hit;
  logic [2:0] src2_hit;
  logic [2:0] stage_hit;
  logic       raw_hazard;

  assign stage[0] = ex_q;
  assign stage[1] = mem_q;
  assign stage[2] = wb_q;

  for (genvar s = 0; s < 3; s++) begin : g_stage
    hazard_match #(.AW(REG_AW)) u_src1 (
      .ent_valid (stage[s].valid),
      .ent_wb_en (stage[s].wb_en),
      .ent_dest  (stage[s].dest),
      .src       (id_src1),
      .src_used  (1'b1),
      .match     (src1_hit[s])
    );
    hazard_match #(.AW(REG_AW)) u_src2 (
      .ent_valid (stage[s].valid),
      .ent_wb_en (stage[s].wb_en),
      .ent_dest  (stage[s].dest),
      .src       (id_src2),
      .src_used  (id_two_src),
      .match     (src2_hit[s])
    );
  end

  assign stage_hit = src1_hit | src2_hit;

  always_comb begin
    raw_hazard = 1'b0;
`ifdef HAZARD_FORWARDING_EN
    // Everything but a load result can be forwarded, so only load-use stalls.
    raw_hazard = stage_hit[0] && ex_q.mem_read;
`else
    raw_hazard = stage_hit[0] || stage_hit[1] || ((WB_HAZARD != 0) && stage_hit[2]);
`endif
    // A squashed or empty ID slot never stalls; the branch wins over the hazard.
    hazard_detected = id_valid && !branch_taken && raw_hazard;
  end

`ifdef HAZARD_FORWARDING_EN
  logic fa_mem, fa_wb, fb_mem, fb_wb;

  hazard_match #(.AW(REG_AW)) u_fa_mem (
    .ent_valid (mem_q.valid), .ent_wb_en (mem_q.wb_en), .ent_dest (mem_q.dest),
    .src (ex_q.src1), .src_used (1'b1), .match (fa_mem)
  );
  hazard_match #(.AW(REG_AW)) u_fa_wb (
    .ent_valid (wb_q.valid), .ent_wb_en (wb_q.wb_en), .ent_dest (wb_q.dest),
    .src (ex_q.src1), .src_used (1'b1), .match (fa_wb)
  );
  hazard_match #(.AW(REG_AW)) u_fb_mem (
    .ent_valid (mem_q.valid), .ent_wb_en (mem_q.wb_en), .ent_dest (mem_q.dest),
    .src (ex_q.src2), .src_used (ex_q.two_src), .match (fb_mem)
  );
  hazard_match #(.AW(REG_AW)) u_fb_wb (
    .ent_valid (wb_q.valid), .ent_wb_en (wb_q.wb_en), .ent_dest (wb_q.dest),
    .src (ex_q.src2), .src_used (ex_q.two_src), .match (fb_wb)
  );

  // The youngest writer (mem) has priority; a load in mem has no data yet on
  // EX/MEM, so it falls through to the MEM/WB/register-file choice.
  always_comb begin
    fwd_sel_a = FWD_NONE;
    if (fa_mem && !mem_q.mem_read) begin
      fwd_sel_a = FWD_EXMEM;
    end else if (fa_wb) begin
      fwd_sel_a = FWD_MEMWB;
    end
    fwd_sel_b = FWD_NONE;
    if (fb_mem && !mem_q.mem_read) begin
      fwd_sel_b = FWD_EXMEM;
    end else if (fb_wb) begin
      fwd_sel_b = FWD_MEMWB;
    end
  end
`endif

  always_comb begin
    ex_d = '0;
    if (id_valid && !hazard_detected && !branch_taken) begin
      ex_d.valid    = 1'b1;
      ex_d.wb_en    = id_wb_en;
      ex_d.mem_read = id_mem_read;
      ex_d.dest     = id_dest;
      ex_d.src1     = id_src1;
      ex_d.src2     = id_src2;
      ex_d.two_src  = id_two_src;
    end
    mem_d = ex_q;
    wb_d  = mem_q;

    stall_cnt_d = stall_cnt_q;
    if (hazard_detected && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

  // WB only needs its writer fields; source fields ride along for uniformity.
  logic sb_unused;
  assign sb_unused = ^{wb_q, ex_q.mem_read, mem_q.mem_read, stage_hit};

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int TB_CNT_W = 6;
`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                clk;
  logic                rst_n;
  logic                id_valid;
  logic [4:0]          id_src1;
  logic [4:0]          id_src2;
  logic                id_two_src;
  logic [4:0]          id_dest;
  logic                id_wb_en;
  logic                id_mem_read;
  logic                branch_taken;
  logic                hazard_detected;
  logic [TB_CNT_W-1:0] stall_cnt;
`ifdef HAZARD_FORWARDING_EN
  logic [1:0]          fwd_sel_a;
  logic [1:0]          fwd_sel_b;
`endif

  int n_cmp = 0;
  int n_err = 0;

  hazard_scoreboard #(.CNT_W(TB_CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_src1         (id_src1),
    .id_src2         (id_src2),
    .id_two_src      (id_two_src),
    .id_dest         (id_dest),
    .id_wb_en        (id_wb_en),
    .id_mem_read     (id_mem_read),
    .branch_taken    (branch_taken),
    .hazard_detected (hazard_detected),
    .stall_cnt       (stall_cnt)
`ifdef HAZARD_FORWARDING_EN
    ,
    .fwd_sel_a       (fwd_sel_a),
    .fwd_sel_b       (fwd_sel_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                       input logic two, input logic [4:0] d, input logic wb,
                       input logic mr, input logic br);
    id_valid     = v;
    id_src1      = s1;
    id_src2      = s2;
    id_two_src   = two;
    id_dest      = d;
    id_wb_en     = wb;
    id_mem_read  = mr;
    branch_taken = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("reset_hazard", hazard_detected, 0);
    chk("reset_cnt", stall_cnt, 0);
`ifdef HAZARD_FORWARDING_EN
    chk("reset_fwd_a", fwd_sel_a, 2'b00);
    chk("reset_fwd_b", fwd_sel_b, 2'b00);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef HAZARD_FORWARDING_EN
    // LD r5 ; ADD r6,r5,r1 -> one load-use stall, then MEM/WB forward on A.
    drive(1, 1, 0, 0, 5, 1, 1, 0);
    chk("ld_issue_hazard", hazard_detected, 0);
    tick();
    drive(1, 5, 1, 1, 6, 1, 0, 0);
    chk("loaduse_stall", hazard_detected, 1);
    tick();
    chk("loaduse_release", hazard_detected, 0);
    tick();
    chk("loaduse_fwd_a", fwd_sel_a, 2'b10);
    chk("loaduse_fwd_b", fwd_sel_b, 2'b00);
    // ADD r2 ; SUB r8,r4,r2 -> no stall, EX/MEM forward on B.
    drive(1, 1, 0, 0, 2, 1, 0, 0);
    chk("add_r2_hazard", hazard_detected, 0);
    tick();
    drive(1, 4, 2, 1, 8, 1, 0, 0);
    chk("sub_no_stall", hazard_detected, 0);
    tick();
    chk("sub_fwd_b", fwd_sel_b, 2'b01);
    chk("sub_fwd_a", fwd_sel_a, 2'b00);
    // ADDI with src2 field = r2 (in wb) but one source: B stays on the register file.
    drive(1, 8, 2, 0, 9, 1, 0, 0);
    tick();
    chk("addi_fwd_b", fwd_sel_b, 2'b00);
    chk("addi_fwd_a", fwd_sel_a, 2'b01);
    drain();
    chk("fwd_cnt", stall_cnt, 1);
`else
    // ADD r3 ; SUB r4,r3,r1 -> two stall cycles then issue.
    drive(1, 1, 2, 1, 3, 1, 0, 0);
    chk("add_issue_hazard", hazard_detected, 0);
    tick();
    drive(1, 3, 1, 1, 4, 1, 0, 0);
    chk("raw_stall_ex", hazard_detected, 1);
    tick();
    chk("raw_stall_mem", hazard_detected, 1);
    tick();
    chk("raw_release_wb", hazard_detected, 0);
    chk("raw_cnt", stall_cnt, 2);
    tick();
    drive(1, 4, 0, 0, 0, 0, 0, 0);
    chk("gate_valid_on", hazard_detected, 1);
    drive(0, 4, 0, 0, 0, 0, 0, 0);
    chk("gate_valid_off", hazard_detected, 0);
    drain();
`endif

    // Writer of r0 followed by readers of r0: never a hazard.
    drive(1, 1, 1, 1, 0, 1, 0, 0);
    chk("r0_writer", hazard_detected, 0);
    tick();
    drive(1, 0, 0, 1, 5, 1, 0, 0);
    chk("r0_reader_ex", hazard_detected, 0);
    tick();
    drive(1, 0, 0, 1, 0, 1, 0, 0);
    chk("r0_reader_mem", hazard_detected, 0);
    drain();

    // LD r7 ; ADDI with src2 field r7: unused src2 ignored, used src2 stalls.
    drive(1, 1, 0, 0, 7, 1, 1, 0);
    tick();
    drive(1, 1, 7, 0, 8, 1, 0, 0);
    chk("addi_one_src", hazard_detected, 0);
    drive(1, 1, 7, 1, 8, 1, 0, 0);
    chk("two_src_match", hazard_detected, 1);
    drive(1, 1, 7, 0, 8, 1, 0, 0);
    tick();
    drain();

    // LD r9 ; branch_taken with a reader of r9 (dest r10): branch wins, bubble enters ex.
    drive(1, 1, 0, 0, 9, 1, 1, 0);
    tick();
    drive(1, 9, 0, 0, 10, 1, 0, 1);
    chk("branch_wins", hazard_detected, 0);
    tick();
    drive(1, 10, 0, 0, 11, 1, 0, 0);
    chk("branch_bubble", hazard_detected, 0);
    drive(1, 9, 0, 0, 11, 1, 0, 0);
    chk("branch_ld_in_mem", hazard_detected, FWD ? 0 : 1);
    chk("branch_cnt", stall_cnt, FWD ? 1 : 2);
    drain();

    // Reset pulsed while a stall is being raised.
    drive(1, 1, 0, 0, 11, 1, 1, 0);
    tick();
    drive(1, 11, 0, 0, 12, 1, 0, 0);
    chk("pre_reset_stall", hazard_detected, 1);
    chk("pre_reset_cnt", stall_cnt, FWD ? 1 : 2);
    rst_n = 1'b0;
    #1;
    chk("async_reset_hazard", hazard_detected, 0);
    chk("async_reset_cnt", stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Self-dependent load repeated: drives the counter into saturation.
    drive(1, 12, 0, 0, 12, 1, 1, 0);
    chk("post_reset_hazard", hazard_detected, 0);
    repeat (9) tick();
    chk("cnt_9_cycles", stall_cnt, FWD ? 4 : 6);
    repeat (141) tick();
    chk("cnt_saturated", stall_cnt, 6'h3F);
    repeat (3) tick();
    chk("cnt_holds", stall_cnt, 6'h3F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer of the `hazard_detected` input consumed by the ID-stage controller.
- Tracks pending register-file writers in the EX, MEM and WB stages of the 5-stage MIPS pipeline.
- Compares them against the ID-stage instruction's sources and raises a stall; optionally generates EX-stage forwarding selects.
- Sits beside the ID/EX pipeline register and is fed by the controller's decoded `WB_EN`/`Mem_Read_EN` and the register-field decode.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, width of the stall performance counter.
- WB_HAZARD, 0: 1 = a writer in WB also causes a hazard, for a register file without write-before-read.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_src1  in  REG_AW  first source register.
- id_src2  in  REG_AW  second source register.
- id_two_src  in  1  src2 is read (R-type, ST, BNE).
- id_dest  in  REG_AW  destination register.
- id_wb_en  in  1  controller WB_EN for the ID instruction.
- id_mem_read  in  1  controller Mem_Read_EN for the ID instruction.
- branch_taken  in  1  branch resolved taken this cycle; the ID instruction is squashed.
- hazard_detected  out  1  stall IF/ID, bubble into ID/EX.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- fwd_sel_a, fwd_sel_b  out  2 each  EX operand selects; present only with the optional feature.

Behaviour:
- Scoreboard is three registered entries: ex, mem, wb.
- Each entry holds valid, wb_en, mem_read, dest, src1, src2, two_src.
- Reset (asynchronous, rst_n=0): all entry fields 0, stall_cnt=0.
- Reset outputs: hazard_detected=0, fwd_sel_a=fwd_sel_b=2'b00.
- Reset mid-operation discards all pending entries immediately; no stall persists after release.
- Every clk edge: wb<=mem; mem<=ex.
- ex<=ID entry when id_valid && !hazard_detected && !branch_taken. Otherwise ex<=bubble (all zero).
- Match rule: stage S matches source r when S.valid && S.wb_en && S.dest==r && r!=0. Register 0 never causes a hazard.
- A source is checked only if used: src1 always; src2 only when id_two_src=1.
- hazard_detected is combinational from current ID inputs and registered entries, gated by id_valid && !branch_taken.
- Without forwarding: hazard if any used source matches ex or mem. Also wb when WB_HAZARD=1.
- Latency without forwarding: a dependent instruction directly after its producer stalls 2 cycles (3 with WB_HAZARD=1).
- stall_cnt increments by 1 each cycle hazard_detected=1 and holds at all-ones (no wrap).
- Simultaneous branch_taken and a would-be hazard: branch wins, hazard_detected=0, bubble enters ex, no count.
- The stall repeats each cycle until the producer leaves the checked stages; no internal state beyond the scoreboard.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- Defined:
  - hazard raised only for load-use, i.e. a used source matches ex with ex.mem_read=1. Exactly 1 stall cycle.
  - fwd_sel_a/b are computed from ex.src1/ex.src2 against mem and wb entries.
  - 2'b01 = from EX/MEM (mem stage, priority), 2'b10 = from MEM/WB, 2'b00 = register file.
  - A mem-stage match with mem.mem_read=1 never selects 01; load data comes only from MEM/WB.
  - fwd_sel_b is 00 when ex.two_src=0.
- Undefined: fwd ports absent; full-stall behaviour above.

Decomposition:
- Shared package/defines: REG_AW, FWD_NONE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, and the scoreboard entry struct/field layout.
- One natural sub-module: hazard_match, the combinational stage-vs-source comparator. Instantiate it per stage/source pair.

Test Plan:
- ADD r3 in EX, ID reads r3 as src1, no forwarding → hazard_detected=1 for 2 cycles, stall_cnt=2, then 0.
- ID reads r0, EX writes r0 → hazard_detected=0 throughout.
- With HAZARD_FORWARDING_EN: LD r5 then ADD r6,r5,r1 → 1 stall cycle; next cycle fwd_sel_a=2'b10.
- With HAZARD_FORWARDING_EN: ADD r2 then SUB using r2 as src2 → no stall, fwd_sel_b=2'b01.
- ADDI (id_two_src=0) with src2 field equal to EX dest → no hazard.
- branch_taken=1 concurrent with a matching source → hazard_detected=0, ex bubble.
- stall_cnt forced near max saturates at 16'hFFFF.
- rst_n pulsed low mid-stall → all entries cleared and hazard_detected=0 asynchronously.
